// File: rtl/adc_pkg.sv
// Shared types, config-word constants and channel-scan helpers for the
// LTC2308-style ADC sequencer.
package adc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_SHIFT
   } state_t;

   localparam logic SD_SINGLE = 1'b1;
   localparam logic SLEEP_OFF = 1'b0;

   // Next set bit strictly above 'last', ascending, wrapping; returns 'last' for an empty mask.
   function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] last);
      logic [2:0] sel;
      logic [2:0] c;
      logic       found;
      sel   = last;
      found = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         c = last + 3'(i);
         if (!found && mask[c]) begin
            sel   = c;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   // The ADC's channel field is odd/sign-select first, then the two upper channel bits.
   function automatic logic [5:0] cfg_word(input logic [2:0] ch, input logic uni);
      return {SD_SINGLE, ch[0], ch[2], ch[1], uni, SLEEP_OFF};
   endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SPI serial-clock divider: SCLK idles low, toggles every CLK_DIV cycles while run is high,
// and flags the cycle whose closing edge moves SCLK up or down.
module adc_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] cnt;
   logic             edge_due;

   assign edge_due = run && (cnt == DIV_W'(CLK_DIV - 1));
   assign rise     = edge_due && !sclk;
   assign fall     = edge_due && sclk;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (edge_due) begin
         cnt  <= '0;
         sclk <= !sclk;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Round-robin multi-channel sequencer for the SPI SAR ADC: one config word out and the
// previous frame's conversion in per CS_N-low window, tagged with its channel.
module adc_seq_ctrl
   import adc_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int DATA_W      = 12,
   parameter int CLK_DIV     = 2,
   parameter int CONV_CYCLES = 80,
   parameter bit UNIPOLAR    = 1'b1
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              enable,
   input  logic              mode,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic              sample_valid,
   output logic [DATA_W-1:0] sample_data,
   output logic [2:0]        sample_ch,
   output logic              busy,
   output logic              ADC_CS_N,
   output logic              ADC_SCLK,
   output logic              ADC_DIN,
   input  logic              ADC_DOUT
);

   localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam int BIT_W  = $clog2(DATA_W + 1);

   state_t            state;
   logic [CONV_W-1:0] conv_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] din_sr;
   logic [DATA_W-1:0] dout_sr;
   logic [2:0]        ptr;
   logic [2:0]        tag_p0;
   logic [2:0]        tag_p1;
   logic              primed;
   logic              cont;

   logic [7:0]        mask8;
   logic              mask_any;
   logic              run_ok;
   logic              conv_done;
   logic              shift_done;
   logic              sclk_rise;
   logic              sclk_fall;
   logic [2:0]        sel_ch;
   logic [DATA_W-1:0] cfg_frame;

   always_comb begin
      mask8               = '0;
      mask8[NUM_CH-1:0]   = ch_mask;
   end

   assign mask_any   = (mask8 != '0);
   assign run_ok     = enable && mask_any && (mode == cont);
   assign conv_done  = (conv_cnt == CONV_W'(CONV_CYCLES - 1));
   assign shift_done = sclk_fall && (bit_cnt == BIT_W'(DATA_W));

   // A primed scan continues past the last channel sent; a fresh scan starts at the pointer.
   assign sel_ch    = primed ? next_ch(mask8, tag_p0) : next_ch(mask8, ptr - 3'd1);
   assign cfg_frame = DATA_W'(cfg_word(sel_ch, UNIPOLAR)) << (DATA_W - 6);

   adc_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk (
      .clk  (CLOCK_50),
      .rst  (RESET),
      .run  (state == ST_SHIFT),
      .sclk (ADC_SCLK),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   // Serial datapath: config bits leave on SCLK falls, result bits arrive on SCLK rises.
   always_ff @(posedge CLOCK_50) begin
      if (state == ST_CONV && conv_done) begin
         din_sr <= cfg_frame << 1;
      end else if (sclk_fall) begin
         din_sr <= din_sr << 1;
      end
      if (sclk_rise) begin
         dout_sr <= {dout_sr[DATA_W-2:0], ADC_DOUT};
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state        <= ST_IDLE;
         conv_cnt     <= '0;
         bit_cnt      <= '0;
         ptr          <= 3'd0;
         tag_p0       <= 3'd0;
         tag_p1       <= 3'd0;
         primed       <= 1'b0;
         cont         <= 1'b0;
         ADC_CS_N     <= 1'b1;
         ADC_DIN      <= 1'b0;
         sample_valid <= 1'b0;
         sample_data  <= '0;
         sample_ch    <= 3'd0;
         busy         <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable && mask_any && (mode || start)) begin
                  state    <= ST_CONV;
                  cont     <= mode;
                  conv_cnt <= '0;
                  primed   <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            ST_CONV: begin
               // CS_N is already high here, so stopping cannot truncate a frame.
               if (!run_ok) begin
                  state  <= ST_IDLE;
                  busy   <= 1'b0;
                  primed <= 1'b0;
                  if (primed) ptr <= tag_p0;
               end else if (conv_done) begin
                  state    <= ST_SHIFT;
                  ADC_CS_N <= 1'b0;
                  ADC_DIN  <= cfg_frame[DATA_W-1];
                  bit_cnt  <= '0;
                  tag_p0   <= sel_ch;
                  tag_p1   <= tag_p0;
               end else begin
                  conv_cnt <= conv_cnt + 1'b1;
               end
            end

            ST_SHIFT: begin
               if (sclk_rise) bit_cnt <= bit_cnt + 1'b1;
               if (shift_done) begin
                  ADC_CS_N <= 1'b1;
                  ADC_DIN  <= 1'b0;
                  conv_cnt <= '0;
                  if (primed) begin
                     sample_valid <= 1'b1;
                     sample_data  <= dout_sr;
                     sample_ch    <= tag_p1;
                  end
                  // Single-shot ends after its one read frame; continuous runs while allowed.
                  if (run_ok && (cont || !primed)) begin
                     state  <= ST_CONV;
                     primed <= 1'b1;
                  end else begin
                     state  <= ST_IDLE;
                     busy   <= 1'b0;
                     primed <= 1'b0;
                     ptr    <= tag_p0;
                  end
               end else if (sclk_fall) begin
                  ADC_DIN <= din_sr[DATA_W-1];
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl with a behavioural LTC2308 model and a result scoreboard.
module tb_adc_seq_ctrl;

   typedef struct packed {
      logic [2:0]  ch;
      logic [11:0] data;
   } exp_t;

   logic        CLOCK_50 = 1'b0;
   logic        RESET;
   logic        enable, mode, start;
   logic [7:0]  ch_mask;
   logic        sample_valid;
   logic [11:0] sample_data;
   logic [2:0]  sample_ch;
   logic        busy, ADC_CS_N, ADC_SCLK, ADC_DIN;
   logic        adc_dout = 1'b0;

   logic        en2;
   logic        valid2, busy2, cs2, sclk2, din2;
   logic [15:0] data2;
   logic [2:0]  ch2;

   always #10 CLOCK_50 = ~CLOCK_50;

   adc_seq_ctrl dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .enable(enable), .mode(mode), .start(start),
      .ch_mask(ch_mask), .sample_valid(sample_valid), .sample_data(sample_data),
      .sample_ch(sample_ch), .busy(busy), .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK),
      .ADC_DIN(ADC_DIN), .ADC_DOUT(adc_dout)
   );

   adc_seq_ctrl #(.NUM_CH(8), .DATA_W(16), .CLK_DIV(1), .CONV_CYCLES(20), .UNIPOLAR(1'b1)) dut2 (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .enable(en2), .mode(1'b1), .start(1'b0),
      .ch_mask(8'h01), .sample_valid(valid2), .sample_data(data2), .sample_ch(ch2),
      .busy(busy2), .ADC_CS_N(cs2), .ADC_SCLK(sclk2), .ADC_DIN(din2), .ADC_DOUT(1'b1)
   );

   int n_pass = 0, n_fail = 0, n_checks = 0;
   int cyc = 0;
   exp_t sb[$];
   int   vcyc[$];

   // ADC model / monitor state for the default-parameter DUT
   logic        cs_prev = 1'b1, sclk_prev = 1'b0;
   logic [11:0] word = '0, din_cap = '0, last_din = '0;
   logic [2:0]  pending = '0;
   int bidx = 0, low_cnt = 0, rises = 0, last_low = 0, last_rises = 0;
   int falls = 0, frames = 0, valid_n = 0, busy_cycles = 0, total_rises = 0;
   logic busy_at_valid = 1'b1;

   // monitor state for the CLK_DIV=1 / DATA_W=16 DUT
   logic cs2_prev = 1'b1, sclk2_prev = 1'b0;
   int low2 = 0, rises2 = 0, last_low2 = 0, last_rises2 = 0, valid2_n = 0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] ch, input logic [11:0] data);
      exp_t e;
      e.ch   = ch;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge CLOCK_50);
         #1;
      end
   endtask

   function automatic int cur(input int sel);
      case (sel)
         0:       return falls;
         1:       return frames;
         2:       return valid_n;
         default: return valid2_n;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int target, input string tag);
      int k = 0;
      while (cur(sel) < target && k < 2000) begin
         tick();
         k++;
      end
      chk(tag, 32'(cur(sel) >= target), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < 1000) begin
         tick();
         k++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   // ADC model: DOUT MSB on CS_N fall, next bit on each SCLK fall; DIN captured on SCLK rise.
   initial forever begin
      @(negedge CLOCK_50);
      if (RESET) begin
         cs_prev   = 1'b1;
         sclk_prev = 1'b0;
         adc_dout  = 1'b0;
      end else begin
         if (!ADC_CS_N && cs_prev) begin
            falls++;
            low_cnt  = 0;
            rises    = 0;
            din_cap  = '0;
            word     = 12'hA5C + 12'(pending);
            bidx     = 11;
            adc_dout = word[11];
         end
         if (!ADC_CS_N) low_cnt++;
         if (ADC_CS_N && !cs_prev) begin
            frames++;
            last_low   = low_cnt;
            last_rises = rises;
            last_din   = din_cap;
            pending    = {din_cap[9], din_cap[8], din_cap[10]};
         end
         if (ADC_SCLK && !sclk_prev) begin
            rises++;
            total_rises++;
            din_cap = {din_cap[10:0], ADC_DIN};
         end
         if (!ADC_SCLK && sclk_prev && !ADC_CS_N) begin
            if (bidx > 0) bidx--;
            adc_dout = word[bidx];
         end
         if (busy) busy_cycles++;
         if (sample_valid) begin
            valid_n++;
            vcyc.push_back(cyc);
            busy_at_valid = busy;
            chk("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("valid_ch", 32'(sample_ch), 32'(e.ch));
               chk("valid_data", 32'(sample_data), 32'(e.data));
            end
         end
         cs_prev   = ADC_CS_N;
         sclk_prev = ADC_SCLK;
      end
   end

   initial forever begin
      @(negedge CLOCK_50);
      if (RESET) begin
         cs2_prev   = 1'b1;
         sclk2_prev = 1'b0;
      end else begin
         if (!cs2 && cs2_prev) begin
            low2   = 0;
            rises2 = 0;
         end
         if (!cs2) low2++;
         if (cs2 && !cs2_prev) begin
            last_low2   = low2;
            last_rises2 = rises2;
         end
         if (sclk2 && !sclk2_prev) rises2++;
         if (valid2) valid2_n++;
         cs2_prev   = cs2;
         sclk2_prev = sclk2;
      end
   end

   initial begin
      int c0, vb, f, v, fr, b, r;
      RESET = 1'b1; enable = 1'b0; mode = 1'b0; start = 1'b0; ch_mask = 8'h00; en2 = 1'b0;
      tick(3);
      chk("rst_cs_n", 32'(ADC_CS_N), 32'd1);
      chk("rst_sclk", 32'(ADC_SCLK), 32'd0);
      chk("rst_din", 32'(ADC_DIN), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_data", 32'(sample_data), 32'd0);
      chk("rst_ch", 32'(sample_ch), 32'd0);
      RESET = 1'b0;
      tick(2);

      // CLK_DIV=1, DATA_W=16 instance: 32-cycle window, 16 rises, DOUT tied high
      en2 = 1'b1;
      wait_for(3, 1, "d2_valid_seen");
      chk("d2_low_len", 32'(last_low2), 32'd32);
      chk("d2_rises", 32'(last_rises2), 32'd16);
      chk("d2_data", 32'(data2), 32'h0000_FFFF);
      chk("d2_ch", 32'(ch2), 32'd0);
      en2 = 1'b0;
      tick(5);

      // continuous scan of channels 0, 2, 7
      push(3'd0, 12'hA5C); push(3'd2, 12'hA5E); push(3'd7, 12'hA63);
      push(3'd0, 12'hA5C); push(3'd2, 12'hA5E);
      ch_mask = 8'b1000_0101; mode = 1'b1; enable = 1'b1;
      c0 = cyc;
      vb = vcyc.size();
      wait_for(2, 4, "cont_4_valids");
      chk("cont_first_latency", 32'(vcyc[vb] - c0), 32'd257);
      chk("cont_spacing_1", 32'(vcyc[vb+1] - vcyc[vb]), 32'd128);
      chk("cont_spacing_2", 32'(vcyc[vb+2] - vcyc[vb+1]), 32'd128);
      chk("cont_frame_len", 32'(last_low), 32'd48);

      // enable dropped ten cycles into a window: window completes, result still emitted
      f = falls;
      wait_for(0, f + 1, "drop_window_start");
      tick(10);
      enable = 1'b0;
      wait_for(2, 5, "drop_valid");
      chk("drop_len", 32'(last_low), 32'd48);
      chk("drop_busy_at_valid", 32'(busy_at_valid), 32'd0);
      f = falls;
      tick(300);
      chk("drop_stays_idle", 32'(falls - f), 32'd0);

      // re-enable on channel 5: prime frame without a valid, then the read
      ch_mask = 8'h20; enable = 1'b1;
      push(3'd5, 12'hA61);
      fr = frames;
      wait_for(1, fr + 1, "prime_end");
      chk("prime_din", 32'(last_din), 32'h0000_0E80);
      chk("prime_rises", 32'(last_rises), 32'd12);
      chk("prime_len", 32'(last_low), 32'd48);
      chk("prime_no_valid", 32'(valid_n), 32'd5);
      wait_for(2, 6, "ch5_valid");
      enable = 1'b0;
      wait_idle("ch5_stop_idle");

      // single-shot on channel 4, second start while busy is ignored
      mode = 1'b0; ch_mask = 8'h10; enable = 1'b1;
      f = falls;
      v = valid_n;
      push(3'd4, 12'hA60);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ss_busy_next", 32'(busy), 32'd1);
      chk("ss_cs_high", 32'(ADC_CS_N), 32'd1);
      tick(200);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle("ss_idle");
      chk("ss_windows", 32'(falls - f), 32'd2);
      chk("ss_valids", 32'(valid_n - v), 32'd1);
      tick(300);
      chk("ss_no_restart", 32'(falls - f), 32'd2);

      // empty mask never leaves IDLE
      ch_mask = 8'h00; mode = 1'b1; enable = 1'b1;
      f = falls;
      b = busy_cycles;
      r = total_rises;
      tick(1000);
      chk("mask0_no_window", 32'(falls - f), 32'd0);
      chk("mask0_never_busy", 32'(busy_cycles - b), 32'd0);
      chk("mask0_no_sclk", 32'(total_rises - r), 32'd0);
      chk("mask0_cs_high", 32'(ADC_CS_N), 32'd1);
      enable = 1'b0;
      tick(2);

      // reset in the middle of a window while SCLK and DIN are both high
      ch_mask = 8'h01; enable = 1'b1;
      f = falls;
      wait_for(0, f + 1, "rst_window_start");
      tick(18);
      chk("pre_rst_sclk", 32'(ADC_SCLK), 32'd1);
      chk("pre_rst_din", 32'(ADC_DIN), 32'd1);
      RESET = 1'b1;
      tick();
      chk("midrst_cs_n", 32'(ADC_CS_N), 32'd1);
      chk("midrst_sclk", 32'(ADC_SCLK), 32'd0);
      chk("midrst_din", 32'(ADC_DIN), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_valid", 32'(sample_valid), 32'd0);
      chk("midrst_data", 32'(sample_data), 32'd0);
      chk("midrst_ch", 32'(sample_ch), 32'd0);
      RESET = 1'b0;
      enable = 1'b0;
      tick(2);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

Parametrised multi-channel sequencer for the board's SPI successive-approximation ADC (LTC2308-style: CONVST via CS_N, 6-bit config on DIN, MSB-first result on DOUT). It replaces the fixed single-channel front end: it scans a run-time channel mask round-robin in continuous or single-shot mode. Each result is presented with its channel tag on a one-cycle valid strobe for the display and capture logic downstream.

## Interface
- NUM_CH, 8: physical channels scanned (1..8); channel tag is always 3 bits.
- DATA_W, 12: result bits per frame, and SCLK periods per frame (≥6).
- CLK_DIV, 2: SCLK half-period in CLOCK_50 cycles (≥1); SCLK = 50 MHz / (2·CLK_DIV).
- CONV_CYCLES, 80: CS_N-high conversion time in cycles (80 = 1.6 µs).
- UNIPOLAR, 1: UNI bit of config word.

Ports:
- CLOCK_50  in  1  system clock; sole clock.
- RESET  in  1  synchronous, active-high reset.
- enable  in  1  run request; 0 stops after the current frame.
- mode  in  1  0 = single-shot on start, 1 = continuous.
- start  in  1  single-shot trigger pulse; ignored while busy or mode=1.
- ch_mask  in  NUM_CH  enabled channels; bit i = channel i.
- sample_valid  out  1  one-cycle strobe, new result.
- sample_data  out  DATA_W  result, MSB first as shifted.
- sample_ch  out  3  channel of sample_data.
- busy  out  1  high outside IDLE.
- ADC_CS_N  out  1  chip select / CONVST.
- ADC_SCLK  out  1  serial clock, idles low.
- ADC_DIN  out  1  config word to ADC.
- ADC_DOUT  in  1  result bits from ADC.

## Operation
- Reset values: ADC_CS_N=1, ADC_SCLK=0, ADC_DIN=0, sample_valid=0, sample_data=0, sample_ch=0, busy=0; FSM IDLE; pipeline unprimed; channel pointer 0.
- States: IDLE → CONV → SHIFT → (CONV | IDLE).
- IDLE: leave when enable=1, ch_mask≠0 and (mode=1 or start=1). ch_mask=0: stay IDLE, busy=0.
- Channel select: next set bit of ch_mask strictly above the last-selected channel, ascending, wrapping to lowest set bit; from reset/IDLE start at lowest set bit ≥ pointer. Mask sampled once per frame, at SHIFT entry.
- Config word (6 bits, MSB first): {1, ch[0], ch[2], ch[1], UNIPOLAR, 0}; DIN=0 for bits 6..DATA_W-1.
- Pipelining: a frame's DOUT returns the conversion of the config sent in the previous frame. First frame after IDLE is a prime: result discarded, no sample_valid. sample_ch = channel sent in previous frame.
- Continuous: frames repeat while enable=1 and mode=1.
- Single-shot: exactly prime + one read frame, one sample_valid, then IDLE; pointer advances to next enabled channel.
- enable drop, mode change or mask→0 mid-frame: current frame completes (no truncated CS_N-low window), its valid result (if primed) is still emitted, then IDLE; pipeline unprimed.
- RESET mid-frame: all outputs take reset values on that edge; CS_N high immediately.

## Timing
- CONV: CS_N high exactly CONV_CYCLES cycles (also required before the first frame).
- SHIFT: CS_N low exactly 2·CLK_DIV·DATA_W cycles. SCLK low for first CLK_DIV cycles, then toggles every CLK_DIV cycles; DATA_W rising edges, ends low.
- DIN: config MSB valid on CS_N fall; next bit on each SCLK falling edge.
- DOUT sampled on the CLOCK_50 edge that drives SCLK 0→1; shifted in MSB first.
- sample_valid/data/ch asserted on the cycle CS_N returns high; data/ch hold until next valid.
- Defaults: 48 cycles low + 80 high = 128 cycles (2.56 µs) per frame in continuous mode.
- start asserted same cycle as entry condition: busy=1 next cycle, CS_N still high (CONV).

## Structure
- Package adc_pkg: FSM state enum, config-bit constants (SD_SINGLE, SLEEP_OFF), function next_ch(mask, last) returning 3-bit channel.
- Sub-module adc_sclk_gen: CLK_DIV counter producing SCLK plus one-cycle rise/fall strobes, cleared when CS_N high.
- Top holds FSM, bit counter, DIN/DOUT shift registers, pipeline tag register.

## Test plan
- Reset mid-SHIFT (defaults) → next cycle CS_N=1, SCLK=0, DIN=0, busy=0, valid=0.
- Continuous, mask=8'b1000_0101, DOUT model returns 12'hA5C+ch → valids for ch 0,2,7,0,… data 12'hA5C/A5E/A63, first valid after second frame, spacing 128 cycles.
- DIN capture: ch=5, UNIPOLAR=1 → DIN bits 1,1,1,0,1,0 then 0×6 on falling edges; exactly 12 SCLK rises per CS_N low.
- Single-shot, mask=8'h10, start pulse → two CS_N-low windows, one valid with sample_ch=4, busy low after; start while busy ignored.
- enable dropped at cycle 10 of SHIFT → frame completes full 48 cycles, valid emitted, IDLE; re-enable → new prime frame without valid.
- ch_mask=0 with enable=1, mode=1 → CS_N stays 1, busy=0, no SCLK for 1000 cycles; CLK_DIV=1, DATA_W=16 run → 32-cycle CS_N low, 16 SCLK rises.
